imem_ctrl: RTL and testbench

Instruction-memory controller for the CPU fetch stage. It owns the DEPTH-word instruction store and sequences it through two phases: a boot-load phase, in which a host port writes the program while the CPU is stalled, and a run phase, in which the CPU fetches with a registered one-cycle read. Optionally, host writes can also be arbitrated against fetches during run. It sits between the host/loader interface and the CPU fetch logic, which consumes `cpu_instr` and honours `cpu_stall`.

---
 rtl/imem_ctrl.sv | 154 +++++++++++++++
 tb/tb_imem_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imem_ctrl -- instruction-memory controller for the CPU fetch stage.
//
// Owns a DEPTH-word instruction store. After reset it sits in LOAD, where the
// host writes the program while every CPU fetch is stalled. A host_boot_done
// pulse, or filling all DEPTH words, moves it to RUN. In RUN the CPU fetches
// with a registered one-cycle read. Only rst returns the controller to LOAD.
// The store itself is never cleared by reset.
//
// Optional feature macro: IMEM_RUNTIME_WR_EN
//   defined   : host writes are also accepted in RUN. A host write wins over
//               a fetch in the same cycle, and that fetch is stalled.
//   undefined : the store is read-only in RUN (host_wr_ready_o = 0), and
//               fetches are never stalled in RUN.
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous active-high reset
//   host_wr_valid_i   host write request
//   host_wr_ready_o   host write accepted this cycle
//   host_wr_addr_i    host write word address   [ADDR_W]
//   host_wr_data_i    host write data           [DATA_W]
//   host_boot_done_i  pulse that ends the load phase
//   cpu_fetch_req_i   CPU fetch request
//   cpu_addr_i        fetch word address        [ADDR_W]
//   cpu_stall_o       fetch not granted this cycle (combinational)
//   cpu_instr_o       registered fetch data     [DATA_W]
//   cpu_instr_valid_o cpu_instr_o holds the previous cycle's granted fetch
//   run_o             controller is in RUN
//   words_loaded_o    in-range writes accepted during LOAD [$clog2(DEPTH+1)]
//   addr_fault_o      sticky: an out-of-range address was seen
// -----------------------------------------------------------------------------
module imem_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       host_wr_valid_i,
    output logic                       host_wr_ready_o,
    input  logic [ADDR_W-1:0]          host_wr_addr_i,
    input  logic [DATA_W-1:0]          host_wr_data_i,
    input  logic                       host_boot_done_i,
    input  logic                       cpu_fetch_req_i,
    input  logic [ADDR_W-1:0]          cpu_addr_i,
    output logic                       cpu_stall_o,
    output logic [DATA_W-1:0]          cpu_instr_o,
    output logic                       cpu_instr_valid_o,
    output logic                       run_o,
    output logic [$clog2(DEPTH+1)-1:0] words_loaded_o,
    output logic                       addr_fault_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WL_W  = $clog2(DEPTH+1);

`ifdef IMEM_RUNTIME_WR_EN
    localparam logic RUN_WR_READY = 1'b1;
`else
    localparam logic RUN_WR_READY = 1'b0;
`endif

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [WL_W-1:0]   words_loaded_q;
    logic              addr_fault_q;
    logic [DATA_W-1:0] cpu_instr_q;
    logic              cpu_instr_valid_q;

    logic wr_fire;
    logic wr_in_range;
    logic rd_in_range;
    logic grant;
    logic load_count;

    // Compare with one extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    assign wr_in_range = {1'b0, host_wr_addr_i} < (ADDR_W+1)'(DEPTH);
    assign rd_in_range = {1'b0, cpu_addr_i}     < (ADDR_W+1)'(DEPTH);

    // Kept outside the FSM block: wr_fire feeds the next-state logic.
    assign host_wr_ready_o = (state_q == S_LOAD) | RUN_WR_READY;
    assign wr_fire         = host_wr_valid_i & host_wr_ready_o;

    // Host has priority over a fetch in the same cycle.
    assign grant       = (state_q == S_RUN) & cpu_fetch_req_i & ~wr_fire;
    assign cpu_stall_o = cpu_fetch_req_i & ~grant;

    // Only in-range LOAD writes count; the count saturates at DEPTH.
    assign load_count = (state_q == S_LOAD) & wr_fire & wr_in_range &
                        (words_loaded_q != WL_W'(DEPTH));

    // Next-state and state-decoded outputs
    always_comb begin
        state_d = state_q;
        run_o   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (host_boot_done_i ||
                    (load_count && (words_loaded_q == WL_W'(DEPTH-1)))) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                run_o = 1'b1;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_LOAD;
            words_loaded_q    <= '0;
            addr_fault_q      <= 1'b0;
            cpu_instr_q       <= '0;
            cpu_instr_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            cpu_instr_valid_q <= grant;
            // An ungranted fetch leaves the previous instruction in place.
            if (grant) begin
                cpu_instr_q <= rd_in_range ? mem[cpu_addr_i[IDX_W-1:0]] : '0;
            end
            if (load_count) begin
                words_loaded_q <= words_loaded_q + 1'b1;
            end
            if ((wr_fire && !wr_in_range) || (grant && !rd_in_range)) begin
                addr_fault_q <= 1'b1;
            end
        end
    end

    // Store has no reset, so a program survives a reset mid-load.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_range) begin
            mem[host_wr_addr_i[IDX_W-1:0]] <= host_wr_data_i;
        end
    end

    assign cpu_instr_o       = cpu_instr_q;
    assign cpu_instr_valid_o = cpu_instr_valid_q;
    assign words_loaded_o    = words_loaded_q;
    assign addr_fault_o      = addr_fault_q;

endmodule

// File: tb/tb_imem_ctrl.sv
`timescale 1ns/1ps
module tb_imem_ctrl;

    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

`ifdef IMEM_RUNTIME_WR_EN
    localparam bit RTWR = 1'b1;
`else
    localparam bit RTWR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_boot_done;
    logic          cpu_fetch_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_stall;
    logic [DW-1:0] cpu_instr;
    logic          cpu_instr_valid;
    logic          run;
    logic [5:0]    words_loaded;
    logic          addr_fault;

    always #5 clk = ~clk;

    imem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .host_wr_valid_i   (host_wr_valid),
        .host_wr_ready_o   (host_wr_ready),
        .host_wr_addr_i    (host_wr_addr),
        .host_wr_data_i    (host_wr_data),
        .host_boot_done_i  (host_boot_done),
        .cpu_fetch_req_i   (cpu_fetch_req),
        .cpu_addr_i        (cpu_addr),
        .cpu_stall_o       (cpu_stall),
        .cpu_instr_o       (cpu_instr),
        .cpu_instr_valid_o (cpu_instr_valid),
        .run_o             (run),
        .words_loaded_o    (words_loaded),
        .addr_fault_o      (addr_fault)
    );

    typedef struct {
        bit          v;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the controller
    logic [31:0] m_mem [DEPTH];
    bit          m_run;
    int          m_wl;
    bit          m_fault;
    logic [31:0] m_instr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input bit fr);
        rst            = 1'b1;
        host_wr_valid  = 1'b0;
        host_wr_addr   = '0;
        host_wr_data   = '0;
        host_boot_done = 1'b0;
        cpu_fetch_req  = fr;
        cpu_addr       = '0;
        #1;
        check("rst_run",   32'(run),             32'd0);
        check("rst_instr", cpu_instr,            32'd0);
        check("rst_valid", 32'(cpu_instr_valid), 32'd0);
        check("rst_wl",    32'(words_loaded),    32'd0);
        check("rst_fault", 32'(addr_fault),      32'd0);
        check("rst_ready", 32'(host_wr_ready),   32'd1);
        check("rst_stall", 32'(cpu_stall),       32'(fr));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_run   = 1'b0;
        m_wl    = 0;
        m_fault = 1'b0;
        m_instr = 32'h0;
        exp_q.delete();
        $display("reset done (fetch_req=%0d)", fr);
    endtask

    // One clock cycle: drive inputs, check combinational outputs, push the
    // expected fetch result, advance the model, then pop and compare after the edge.
    task automatic cycle(input bit wv, input int wa, input logic [31:0] wd,
                         input bit bd, input bit fr, input int fa);
        bit   rdy, wfire, gnt, next_run;
        exp_t e;
        host_wr_valid  = wv;
        host_wr_addr   = AW'(wa);
        host_wr_data   = wd;
        host_boot_done = bd;
        cpu_fetch_req  = fr;
        cpu_addr       = AW'(fa);
        rdy   = !m_run || RTWR;
        wfire = wv && rdy;
        gnt   = m_run && fr && !wfire;
        #1;
        check("host_wr_ready", 32'(host_wr_ready), 32'(rdy));
        check("cpu_stall",     32'(cpu_stall),     32'(fr && !gnt));

        // Read sees the store before this cycle's write (no forwarding).
        if (gnt) m_instr = (fa < DEPTH) ? m_mem[fa] : 32'h0;
        e.v = gnt;
        e.d = m_instr;
        exp_q.push_back(e);
        if (gnt && fa >= DEPTH) m_fault = 1'b1;

        next_run = m_run || bd;
        if (wfire) begin
            if (wa < DEPTH) begin
                m_mem[wa] = wd;
                if (!m_run && m_wl < DEPTH) begin
                    m_wl++;
                    if (m_wl == DEPTH) next_run = 1'b1;
                end
            end else begin
                m_fault = 1'b1;
            end
        end
        m_run = next_run;

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("instr_valid", 32'(cpu_instr_valid), 32'(e.v));
            check("instr",       cpu_instr,            e.d);
        end
        check("run",          32'(run),          32'(m_run));
        check("words_loaded", 32'(words_loaded), 32'(m_wl));
        check("addr_fault",   32'(addr_fault),   32'(m_fault));
        if (wfire) $display("write addr=%0d data=%h wl=%0d run=%0d", wa, wd, m_wl, m_run);
        if (e.v)   $display("fetch addr=%0d instr=%h", fa, cpu_instr);
    endtask

    task automatic idle();
        cycle(1'b0, 0, 32'h0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        host_wr_valid  = 1'b0;
        host_wr_addr   = '0;
        host_wr_data   = '0;
        host_boot_done = 1'b0;
        cpu_fetch_req  = 1'b0;
        cpu_addr       = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

        // Boot with fetch held high through LOAD
        do_reset(1'b1);
        cycle(1'b1, 0, 32'h3C01_0001, 1'b0, 1'b1, 0);
        cycle(1'b1, 5, 32'h5555_0005, 1'b0, 1'b1, 0);
        cycle(1'b0, 0, 32'h0,         1'b1, 1'b1, 0);
        cycle(1'b0, 0, 32'h0,         1'b0, 1'b1, 0);
        idle();

        // Out-of-range fetch, fault stays set
        cycle(1'b0, 0, 32'h0, 1'b0, 1'b1, 40);
        idle();
        idle();

        // Write/fetch collision on addr 5, then retry
        cycle(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 1'b1, 5);
        cycle(1'b0, 0, 32'h0,         1'b0, 1'b1, 5);
        idle();

        // Reset mid-load after 10 writes plus an out-of-range write
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, i, 32'hA000_0000 + i, 1'b0, 1'b0, 0);
        cycle(1'b1, 33, 32'h0000_0BAD, 1'b0, 1'b0, 0);
        do_reset(1'b0);
        for (int i = 10; i < DEPTH; i++) cycle(1'b1, i, 32'hB000_0000 + i, 1'b0, 1'b0, 0);
        cycle(1'b0, 0, 32'h0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 32'h0, 1'b0, 1'b1, i);
        idle();

        // Fill all words without boot_done, then read them all back
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, i, $urandom, 1'b0, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 0, 32'h0, 1'b0, 1'b1, i);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
